// File: rtl/bus_pkg.sv
// Shared encodings for the bus_core 8-bit CPU: opcodes, ALU functions,
// branch conditions and the special source/destination selectors.
package bus_pkg;

   typedef enum logic [1:0] {
      OP_COPY = 2'b00,
      OP_ALU  = 2'b01,
      OP_IMM  = 2'b10,
      OP_COND = 2'b11
   } opcode_e;

   typedef enum logic [2:0] {
      ALU_OR   = 3'd0,
      ALU_NAND = 3'd1,
      ALU_NOR  = 3'd2,
      ALU_AND  = 3'd3,
      ALU_ADD  = 3'd4,
      ALU_SUB  = 3'd5,
      ALU_XOR  = 3'd6,
      ALU_NOT  = 3'd7
   } alu_func_e;

   typedef enum logic [2:0] {
      COND_NEVER  = 3'd0,
      COND_EQZ    = 3'd1,
      COND_LTZ    = 3'd2,
      COND_LEZ    = 3'd3,
      COND_ALWAYS = 3'd4,
      COND_NEZ    = 3'd5,
      COND_GEZ    = 3'd6,
      COND_GTZ    = 3'd7
   } cond_e;

   localparam logic [2:0] SRC_ZERO = 3'd6;
   localparam logic [2:0] SRC_IO   = 3'd7;
   localparam logic [2:0] DST_NULL = 3'd6;
   localparam logic [2:0] DST_IO   = 3'd7;

endpackage

// File: rtl/bus_alu.sv
// Purely combinational ALU for bus_core; ADD/SUB wrap, no flags are produced.
module bus_alu
   import bus_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  alu_func_e    func,
   output logic [W-1:0] y
);

   always_comb begin
      y = '0;
      case (func)
         ALU_OR:   y = a | b;
         ALU_NAND: y = ~(a & b);
         ALU_NOR:  y = ~(a | b);
         ALU_AND:  y = a & b;
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_XOR:  y = a ^ b;
         ALU_NOT:  y = ~a;
         default:  y = '0;
      endcase
   end

endmodule

// File: rtl/bus_core.sv
// Single-cycle 8-bit CPU datapath: decoder, six-entry register file, ALU,
// signed branch condition unit, program counter and output port register.
module bus_core
   import bus_pkg::*;
#(
   parameter int W    = 8,
   parameter int NREG = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [7:0]   code_in,
   input  logic [W-1:0] data_in,
   output logic [W-1:0] data_out,
   output logic [W-1:0] code_addr_out
);

   opcode_e      op;
   logic [2:0]   fld_a;
   logic [2:0]   fld_b;

   logic [W-1:0] regs_q [NREG];
   logic [W-1:0] regs_d [NREG];
   logic [W-1:0] pc_q;
   logic [W-1:0] pc_d;
   logic [W-1:0] data_out_q;
   logic [W-1:0] data_out_d;

   logic [W-1:0] src_val;
   logic [W-1:0] alu_y;
   logic         r3_zero;
   logic         r3_neg;
   logic         cond_true;

   assign op    = opcode_e'(code_in[7:6]);
   assign fld_a = code_in[5:3];
   assign fld_b = code_in[2:0];

   // SRC_ZERO matches no register, so it falls through to the zero default.
   always_comb begin
      src_val = '0;
      if (fld_a == SRC_IO) begin
         src_val = data_in;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (fld_a == 3'(i)) src_val = regs_q[i];
         end
      end
   end

   bus_alu #(.W(W)) u_alu (
      .a    (regs_q[1]),
      .b    (regs_q[2]),
      .func (alu_func_e'(fld_b)),
      .y    (alu_y)
   );

   always_comb begin
      r3_zero   = (regs_q[3] == '0);
      r3_neg    = regs_q[3][W-1];
      cond_true = 1'b0;
      case (cond_e'(fld_b))
         COND_NEVER:  cond_true = 1'b0;
         COND_EQZ:    cond_true = r3_zero;
         COND_LTZ:    cond_true = r3_neg;
         COND_LEZ:    cond_true = r3_neg | r3_zero;
         COND_ALWAYS: cond_true = 1'b1;
         COND_NEZ:    cond_true = ~r3_zero;
         COND_GEZ:    cond_true = ~r3_neg;
         COND_GTZ:    cond_true = ~r3_neg & ~r3_zero;
         default:     cond_true = 1'b0;
      endcase
   end

   // DST_NULL matches neither a register nor the port, so the value is dropped.
   always_comb begin
      regs_d     = regs_q;
      data_out_d = data_out_q;
      pc_d       = pc_q + W'(1);
      case (op)
         OP_COPY: begin
            if (fld_b == DST_IO) data_out_d = src_val;
            for (int i = 0; i < NREG; i++) begin
               if (fld_b == 3'(i)) regs_d[i] = src_val;
            end
         end
         OP_ALU:  regs_d[3] = alu_y;
         OP_IMM:  regs_d[0] = W'(code_in[5:0]);
         OP_COND: if (cond_true) pc_d = regs_q[0];
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q     <= '{default: '0};
         pc_q       <= '0;
         data_out_q <= '0;
      end else begin
         regs_q     <= regs_d;
         pc_q       <= pc_d;
         data_out_q <= data_out_d;
      end
   end

   assign data_out      = data_out_q;
   assign code_addr_out = pc_q;

endmodule

// File: tb/tb_bus_core.sv
// Randomised self-checking bench for bus_core against an instruction-level
// reference model that works on plain integers.
module tb_bus_core;

   logic       clk;
   logic       rst_n;
   logic [7:0] code_in;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic [7:0] code_addr_out;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_regs [6];
   logic [7:0] m_pc;
   logic [7:0] m_dout;

   bus_core #(.W(8), .NREG(6)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .code_in       (code_in),
      .data_in       (data_in),
      .data_out      (data_out),
      .code_addr_out (code_addr_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction-level model: decode fields as integers and apply the ISA rules.
   task automatic model_exec(input logic [7:0] code, input logic [7:0] din);
      int op, a, b, x, y, r, s, val, nxt;
      bit take;
      op  = int'(code[7:6]);
      a   = int'(code[5:3]);
      b   = int'(code[2:0]);
      nxt = (int'(m_pc) + 1) % 256;
      case (op)
         0: begin
            if (a < 6)       val = int'(m_regs[a]);
            else if (a == 6) val = 0;
            else             val = int'(din);
            if (b < 6)       m_regs[b] = 8'(val);
            else if (b == 7) m_dout = 8'(val);
         end
         1: begin
            x = int'(m_regs[1]);
            y = int'(m_regs[2]);
            case (b)
               0:       r = x | y;
               1:       r = 255 - (x & y);
               2:       r = 255 - (x | y);
               3:       r = x & y;
               4:       r = (x + y) % 256;
               5:       r = (x - y + 256) % 256;
               6:       r = x ^ y;
               default: r = 255 - x;
            endcase
            m_regs[3] = 8'(r);
         end
         2: m_regs[0] = 8'(int'(code[5:0]));
         default: begin
            s = (int'(m_regs[3]) > 127) ? int'(m_regs[3]) - 256 : int'(m_regs[3]);
            case (b)
               0:       take = 1'b0;
               1:       take = (s == 0);
               2:       take = (s < 0);
               3:       take = (s <= 0);
               4:       take = 1'b1;
               5:       take = (s != 0);
               6:       take = (s >= 0);
               default: take = (s > 0);
            endcase
            if (take) nxt = int'(m_regs[0]);
         end
      endcase
      m_pc = 8'(nxt);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 6; i++) m_regs[i] = 8'h00;
      m_pc   = 8'h00;
      m_dout = 8'h00;
   endtask

   task automatic step(input logic [7:0] code, input logic [7:0] din);
      code_in = code;
      data_in = din;
      @(posedge clk);
      #1;
      model_exec(code, din);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      code_in = 8'h00;
      data_in = 8'h00;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (code_addr_out !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_pc: got %h expected 00", code_addr_out);
      end
      checks++;
      if (data_out !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_dout: got %h expected 00", data_out);
      end
      rst_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
         step({2'b00, 3'(n), 3'd7}, 8'h5A);
         checks++;
         if (data_out !== m_dout) begin
            errors++;
            $display("[TB] FAIL reset_reg%0d: got %h expected %h", n, data_out, m_dout);
         end
      end
   endtask

   task automatic test_copy_io();
      logic [7:0] seq [4];
      pulse_reset();
      seq = '{8'b00_111_000, 8'b00_111_011, 8'b00_000_111, 8'b00_011_111};
      for (int k = 0; k < 4; k++) begin
         step(seq[k], 8'hF0);
         checks++;
         if (code_addr_out !== m_pc) begin
            errors++;
            $display("[TB] FAIL copy_pc[%0d]: got %h expected %h", k, code_addr_out, m_pc);
         end
         checks++;
         if (data_out !== m_dout) begin
            errors++;
            $display("[TB] FAIL copy_dout[%0d]: got %h expected %h", k, data_out, m_dout);
         end
      end
   endtask

   task automatic test_cond_negative();
      logic [7:0] seq [5];
      seq = '{8'b10_100000, 8'b11_000_110, 8'b11_000_010, 8'b11_000_000, 8'b11_000_100};
      for (int k = 0; k < 5; k++) begin
         step(seq[k], 8'h00);
         checks++;
         if (code_addr_out !== m_pc) begin
            errors++;
            $display("[TB] FAIL cond_neg_pc[%0d]: got %h expected %h", k, code_addr_out, m_pc);
         end
      end
   endtask

   task automatic test_output_hold();
      logic [7:0] seq [5];
      seq = '{8'b00_111_001, 8'b00_001_111, 8'b10_010101, 8'b01_000_110, 8'b11_000_000};
      for (int k = 0; k < 5; k++) begin
         step(seq[k], (k == 0) ? 8'hF1 : 8'h0C);
         if (k >= 1) begin
            checks++;
            if (data_out !== 8'hF1 || data_out !== m_dout) begin
               errors++;
               $display("[TB] FAIL out_hold[%0d]: got %h expected %h", k, data_out, m_dout);
            end
         end
      end
   endtask

   task automatic test_alu();
      logic [7:0] ops [3];
      logic [7:0] want [3];
      ops  = '{8'b01_000_100, 8'b01_000_101, 8'b01_000_001};
      want = '{8'h00, 8'hFE, 8'hFE};
      step(8'b00_111_001, 8'hFF);
      step(8'b00_111_010, 8'h01);
      for (int k = 0; k < 3; k++) begin
         step(ops[k], 8'h00);
         step(8'b00_011_111, 8'h00);
         checks++;
         if (data_out !== want[k] || data_out !== m_dout) begin
            errors++;
            $display("[TB] FAIL alu_fixed[%0d]: got %h expected %h", k, data_out, m_dout);
         end
      end
      for (int r = 0; r < 3; r++) begin
         for (int f = 0; f < 8; f++) begin
            step(8'b00_111_001, 8'($urandom));
            step(8'b00_111_010, 8'($urandom));
            step({5'b01_000, 3'(f)}, 8'h00);
            step(8'b00_011_111, 8'h00);
            checks++;
            if (data_out !== m_dout) begin
               errors++;
               $display("[TB] FAIL alu_func%0d: got %h expected %h", f, data_out, m_dout);
            end
         end
      end
   endtask

   task automatic test_imm_cond_zero();
      logic [7:0] r3v [2];
      step(8'b10_111111, 8'h00);
      step(8'b00_000_111, 8'h00);
      checks++;
      if (data_out !== m_dout) begin
         errors++;
         $display("[TB] FAIL imm_r0: got %h expected %h", data_out, m_dout);
      end
      r3v = '{8'h00, 8'h7F};
      for (int v = 0; v < 2; v++) begin
         step(8'b00_111_011, r3v[v]);
         step(8'b11_000_001, 8'h00);
         checks++;
         if (code_addr_out !== m_pc) begin
            errors++;
            $display("[TB] FAIL cond_eqz[%0d]: got %h expected %h", v, code_addr_out, m_pc);
         end
         step(8'b11_000_111, 8'h00);
         checks++;
         if (code_addr_out !== m_pc) begin
            errors++;
            $display("[TB] FAIL cond_gtz[%0d]: got %h expected %h", v, code_addr_out, m_pc);
         end
      end
   endtask

   task automatic test_pc_wrap();
      pulse_reset();
      for (int k = 0; k < 256; k++) begin
         step({2'b10, 6'($urandom)}, 8'h00);
         checks++;
         if (code_addr_out !== m_pc) begin
            errors++;
            $display("[TB] FAIL wrap_pc[%0d]: got %h expected %h", k, code_addr_out, m_pc);
         end
      end
      checks++;
      if (code_addr_out !== 8'h00) begin
         errors++;
         $display("[TB] FAIL wrap_final: got %h expected 00", code_addr_out);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         step(8'($urandom), 8'($urandom));
         checks++;
         if (code_addr_out !== m_pc || data_out !== m_dout) begin
            errors++;
            $display("[TB] FAIL rand[%0d]: got pc=%h out=%h expected pc=%h out=%h",
                     k, code_addr_out, data_out, m_pc, m_dout);
         end
      end
      for (int n = 0; n < 6; n++) begin
         step({2'b00, 3'(n), 3'd7}, 8'h00);
         checks++;
         if (data_out !== m_dout) begin
            errors++;
            $display("[TB] FAIL rand_reg%0d: got %h expected %h", n, data_out, m_dout);
         end
      end
   endtask

   task automatic test_async_reset();
      step(8'b10_000101, 8'h00);
      step(8'b11_000_100, 8'h00);
      step(8'b00_111_111, 8'hAB);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (code_addr_out !== 8'h00 || data_out !== 8'h00) begin
         errors++;
         $display("[TB] FAIL async_reset: got pc=%h out=%h expected 00/00", code_addr_out, data_out);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #2;
      for (int n = 0; n < 6; n++) begin
         step({2'b00, 3'(n), 3'd7}, 8'hFF);
         checks++;
         if (data_out !== m_dout) begin
            errors++;
            $display("[TB] FAIL async_reg%0d: got %h expected %h", n, data_out, m_dout);
         end
      end
   endtask

   initial begin
      $display("[TB] starting bus_core bench");
      test_reset();
      test_copy_io();
      test_cond_negative();
      test_output_hold();
      test_alu();
      test_imm_cond_zero();
      test_random();
      test_async_reset();
      test_pc_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
